// File: rtl/clip_record_play_ctrl.sv
// rtl/clip_record_play_ctrl.sv - record/playback sequencer for the two-clip voice recorder
// Runs RECORD/PLAY sessions, generates sample strobes and addresses, and keeps per-clip lengths.
module clip_record_play_ctrl #(
  parameter int SEC_DIV    = 100_000_000,
  parameter int SAMPLE_DIV = 12_500,
  parameter int MAX_SEC    = 9,
  parameter int ADDR_W     = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              switch0,
  input  logic              switch1,
  output logic              recording,
  output logic              playing,
  output logic              active_clip,
  output logic              sample_stb,
  output logic [ADDR_W:0]   mem_addr,
  output logic [3:0]        count,
  output logic              done
);

  localparam int SEC_W = $clog2(SEC_DIV + 1);
  localparam int SMP_W = $clog2(SAMPLE_DIV + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level
  logic [2:0]        rec_sync;
  logic [2:0]        play_sync;
  logic              rec_evt;
  logic              play_evt;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [SEC_W-1:0]  sec_div;
  logic [SMP_W-1:0]  smp_div;
  logic [ADDR_W-1:0] smp_idx;
  logic [3:0]        clip_len [2];

  logic              active;
  logic              sec_tick;
  logic              smp_tick;
  logic              start;
  logic              stop;
  logic              empty_play;
  logic              start_clip;
  logic [3:0]        count_nxt;

  assign active    = (state != S_IDLE);
  assign sec_tick  = active && (sec_div == SEC_W'(SEC_DIV - 1));
  assign smp_tick  = active && (smp_div == SMP_W'(SAMPLE_DIV - 1));
  assign count_nxt = (sec_tick && (count != 4'(MAX_SEC))) ? count + 4'd1 : count;

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    stop       = 1'b0;
    empty_play = 1'b0;
    start_clip = active_clip;
    case (state)
      S_IDLE: begin
        if (rec_evt) begin
          state_nxt  = S_RECORD;
          start      = 1'b1;
          start_clip = switch0;
        end else if (play_evt) begin
          if (clip_len[switch1] != 4'd0) begin
            state_nxt  = S_PLAY;
            start      = 1'b1;
            start_clip = switch1;
          end else begin
            empty_play = 1'b1;
          end
        end
      end
      S_RECORD: stop = rec_evt || (sec_tick && (count_nxt == 4'(MAX_SEC)));
      S_PLAY:   stop = play_evt || (sec_tick && (count_nxt == clip_len[active_clip]));
      default:  state_nxt = S_IDLE;
    endcase
    if (stop) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rec_sync    <= '0;
      play_sync   <= '0;
      rec_evt     <= 1'b0;
      play_evt    <= 1'b0;
      state       <= S_IDLE;
      recording   <= 1'b0;
      playing     <= 1'b0;
      active_clip <= 1'b0;
      sample_stb  <= 1'b0;
      mem_addr    <= '0;
      count       <= '0;
      done        <= 1'b0;
      sec_div     <= '0;
      smp_div     <= '0;
      smp_idx     <= '0;
      clip_len[0] <= '0;
      clip_len[1] <= '0;
    end else begin
      rec_sync   <= {rec_sync[1:0], rec_btn};
      play_sync  <= {play_sync[1:0], play_btn};
      rec_evt    <= rec_sync[1] & ~rec_sync[2];
      play_evt   <= play_sync[1] & ~play_sync[2];
      state      <= state_nxt;
      recording  <= (state_nxt == S_RECORD);
      playing    <= (state_nxt == S_PLAY);
      done       <= stop | empty_play;
      sample_stb <= 1'b0;
      if (start) begin
        active_clip <= start_clip;
        count       <= '0;
        sec_div     <= '0;
        smp_div     <= '0;
        smp_idx     <= '0;
      end else if (active) begin
        count   <= count_nxt;
        sec_div <= sec_tick ? '0 : sec_div + 1'b1;
        smp_div <= smp_tick ? '0 : smp_div + 1'b1;
        // no strobe on the exit edge so every strobe falls inside the session
        if (smp_tick) begin
          smp_idx <= smp_idx + 1'b1;
          if (!stop) begin
            sample_stb <= 1'b1;
            mem_addr   <= {active_clip, smp_idx};
          end
        end
        if (stop && (state == S_RECORD)) clip_len[active_clip] <= count_nxt;
      end
    end
  end

endmodule

// File: tb/tb_clip_record_play_ctrl.sv
// tb/tb_clip_record_play_ctrl.sv - self-checking bench for clip_record_play_ctrl
// Elapsed-time model of sessions compared every cycle, plus literal session checks.
module tb_clip_record_play_ctrl;

  localparam int SEC_DIV    = 20;
  localparam int SAMPLE_DIV = 4;
  localparam int MAX_SEC    = 9;
  localparam int ADDR_W     = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rec_btn = 1'b0;
  logic       play_btn = 1'b0;
  logic       switch0 = 1'b0;
  logic       switch1 = 1'b0;
  logic       recording;
  logic       playing;
  logic       active_clip;
  logic       sample_stb;
  logic [6:0] mem_addr;
  logic [3:0] count;
  logic       done;

  clip_record_play_ctrl #(
    .SEC_DIV(SEC_DIV), .SAMPLE_DIV(SAMPLE_DIV), .MAX_SEC(MAX_SEC), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .rec_btn(rec_btn), .play_btn(play_btn),
    .switch0(switch0), .switch1(switch1), .recording(recording), .playing(playing),
    .active_clip(active_clip), .sample_stb(sample_stb), .mem_addr(mem_addr),
    .count(count), .done(done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int rec_cycles = 0;
  int play_cycles = 0;
  int done_cnt = 0;

  // model: 0 idle, 1 record, 2 play; me = edges since session start
  int       mst = 0;
  int       mclip = 0;
  int       me = 0;
  int       mcount = 0;
  int       mlen [2];
  bit       mstb = 0;
  bit       mdone = 0;
  int       maddr = 0;
  bit [4:0] rh = 0;
  bit [4:0] ph = 0;
  bit       rev;
  bit       pev;

  always @(posedge clock) begin
    if (!reset) begin
      mst = 0; mclip = 0; me = 0; mcount = 0; mlen[0] = 0; mlen[1] = 0;
      mstb = 0; mdone = 0; maddr = 0; rh = 0; ph = 0;
    end else begin
      rh = {rh[3:0], rec_btn};
      ph = {ph[3:0], play_btn};
      rev = rh[3] && !rh[4];
      pev = ph[3] && !ph[4];
      mstb = 0;
      mdone = 0;
      if (mst == 0) begin
        if (rev) begin
          mst = 1; mclip = int'(switch0); me = 0; mcount = 0;
        end else if (pev) begin
          if (mlen[int'(switch1)] != 0) begin
            mst = 2; mclip = int'(switch1); me = 0; mcount = 0;
          end else begin
            mdone = 1;
          end
        end
      end else begin
        me++;
        mcount = (me / SEC_DIV > MAX_SEC) ? MAX_SEC : me / SEC_DIV;
        if ((mst == 1 && (rev || me == MAX_SEC * SEC_DIV)) ||
            (mst == 2 && (pev || me == mlen[mclip] * SEC_DIV))) begin
          if (mst == 1) mlen[mclip] = mcount;
          mst = 0;
          mdone = 1;
        end else if (me % SAMPLE_DIV == 0) begin
          mstb = 1;
          maddr = mclip * 64 + (me / SAMPLE_DIV - 1) % 64;
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (recording) rec_cycles++;
    if (playing) play_cycles++;
    if (done) done_cnt++;
    if (!reset) begin
      check("rst_recording", int'(recording), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_done", int'(done), 0);
      check("rst_count", int'(count), 0);
      check("rst_addr", int'(mem_addr), 0);
    end else begin
      check("recording", int'(recording), int'(mst == 1));
      check("playing", int'(playing), int'(mst == 2));
      check("done", int'(done), int'(mdone));
      check("count", int'(count), mcount);
      check("sample_stb", int'(sample_stb), int'(mstb));
      check("mem_addr", int'(mem_addr), maddr);
      if (mst != 0) check("active_clip", int'(active_clip), mclip);
    end
  endtask

  task automatic press_rec();
    rec_btn = 1'b1; tick(); tick(); rec_btn = 1'b0;
  endtask

  task automatic press_play();
    play_btn = 1'b1; tick(); tick(); play_btn = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, int'(done), 1);
  endtask

  initial begin
    int used;
    int snap;
    int dsnap;

    // 1: reset, then play of an empty clip
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t1_recording", int'(recording), 0);
    check("t1_count", int'(count), 0);
    snap = play_cycles;
    press_play();
    wait_done("t1", 20);
    check("t1_no_play", play_cycles - snap, 0);

    // 2: record clip 2 for 65 cycles
    switch0 = 1'b1;
    press_rec();
    used = 2;
    while (!sample_stb && used < 20) begin tick(); used++; end
    check("t2_first_stb_cycle", used, 8);
    check("t2_addr0", int'(mem_addr), 7'h40);
    check("t2_recording", int'(recording), 1);
    check("t2_clip", int'(active_clip), 1);
    repeat (4) tick();
    used += 4;
    check("t2_addr1", int'(mem_addr), 7'h41);
    repeat (65 - used) tick();
    press_rec();
    wait_done("t2", 20);
    check("t2_count", int'(count), 3);
    check("t2_exit", int'(recording), 0);
    tick();
    check("t2_done_once", int'(done), 0);

    // 3: play clip 2, auto-exit after 3 seconds
    switch1 = 1'b1;
    snap = play_cycles;
    press_play();
    wait_done("t3", 100);
    check("t3_play_len", play_cycles - snap, 60);
    check("t3_count", int'(count), 3);

    // 4: record clip 1 until the length limit
    switch0 = 1'b0;
    snap = rec_cycles;
    press_rec();
    wait_done("t4", 250);
    check("t4_rec_len", rec_cycles - snap, 180);
    check("t4_count", int'(count), 9);

    // 5: simultaneous buttons, switch change and play press during record
    tick();
    rec_btn = 1'b1; play_btn = 1'b1;
    tick(); tick();
    rec_btn = 1'b0; play_btn = 1'b0;
    repeat (4) tick();
    check("t5_recording", int'(recording), 1);
    check("t5_playing", int'(playing), 0);
    check("t5_clip", int'(active_clip), 0);
    switch0 = 1'b1;
    repeat (5) tick();
    press_play();
    repeat (15) tick();
    check("t5_clip_held", int'(active_clip), 0);
    check("t5_still_rec", int'(recording), 1);
    press_rec();
    wait_done("t5", 40);

    // 6: reset during play wipes lengths
    switch1 = 1'b1;
    press_play();
    repeat (10) tick();
    check("t6_playing", int'(playing), 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_async_playing", int'(playing), 0);
    check("t6_async_count", int'(count), 0);
    check("t6_async_clip", int'(active_clip), 0);
    check("t6_async_addr", int'(mem_addr), 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    snap = play_cycles;
    dsnap = done_cnt;
    switch1 = 1'b0;
    press_play();
    wait_done("t6a", 20);
    tick();
    switch1 = 1'b1;
    press_play();
    wait_done("t6b", 20);
    tick();
    check("t6_no_play", play_cycles - snap, 0);
    check("t6_done_pulses", done_cnt - dsnap, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
